// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues one word read per cycle to a 1-cycle instruction memory and
// buffers returned instructions in a DEPTH-entry FIFO feeding decode over valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_INST = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_inst,
  output logic [31:0]              dec_pc,
  output logic                     dec_fault,
  output logic [63:0]              fetch_dec_reg,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [32:0]  PcLimit = 33'(NUM_INST) << 2;
  localparam logic [PtrW+1:0] DepthW = (PtrW+2)'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW+1)'(1);
  localparam logic [31:0]     NopInst = 32'h0000_0013;

  logic [31:0]                fetch_pc_q;
  logic                       inflight_q;
  logic [31:0]                inflight_pc_q;
  logic                       inflight_fault_q;
  // Entry layout: {fault, inst, pc}
  logic [DEPTH-1:0][64:0]     entry_q;
  logic [PtrW-1:0]            rd_ptr_q;
  logic [PtrW-1:0]            wr_ptr_q;
  logic [PtrW:0]              count_q;

  logic                       in_range;
  logic                       push;
  logic                       pop;
  logic                       issue;
  logic [PtrW+1:0]            used;
  logic [PtrW+1:0]            limit;
  logic [64:0]                head;
  logic                       unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    in_range  = {1'b0, fetch_pc_q} < PcLimit;
    dec_valid = (count_q != '0) && !redirect;
    pop       = dec_valid && dec_ready;
    push      = inflight_q && !redirect;
    used      = {1'b0, count_q} + {{(PtrW+1){1'b0}}, inflight_q};
    // A pop this cycle frees its slot immediately, so issue can resume without a bubble.
    limit     = DepthW + {{(PtrW+1){1'b0}}, pop};
    issue     = !rst && !redirect && (used < limit);
    imem_req  = issue && in_range;
    imem_addr = fetch_pc_q;
    head      = entry_q[rd_ptr_q];
  end

  assign dec_fault     = head[64];
  assign dec_inst      = head[63:32];
  assign dec_pc        = head[31:0];
  assign fetch_dec_reg = {dec_inst, dec_pc};
  assign occupancy     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_fault_q <= 1'b0;
      entry_q          <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else if (redirect) begin
      // Dropping inflight discards the read data returning next cycle.
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        inflight_q       <= 1'b1;
        inflight_pc_q    <= fetch_pc_q;
        inflight_fault_q <= !in_range;
        fetch_pc_q       <= fetch_pc_q + 32'd4;
      end else if (push) begin
        inflight_q <= 1'b0;
      end
      if (push) begin
        entry_q[wr_ptr_q] <= {inflight_fault_q, inflight_fault_q ? NopInst : imem_rdata,
                              inflight_pc_q};
        wr_ptr_q          <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, NUM_INST=4): stimulus queues expected decode
// entries, a negedge monitor pops and compares every accepted decode handshake.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_fault;
  logic [63:0] fetch_dec_reg;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;

  fetch_queue #(
    .DEPTH    (4),
    .NUM_INST (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .dec_fault     (dec_fault),
    .fetch_dec_reg (fetch_dec_reg),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  // Synchronous memory, word i holds i; garbage when not read so fault NOPs are visible.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

  function automatic logic [64:0] exp_entry(input logic [31:0] pc);
    if (pc < 32'd16) return {1'b0, pc >> 2, pc};
    return {1'b1, 32'h0000_0013, pc};
  endfunction

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_entry(start + 32'(4 * i)));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (!dec_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(dec_valid), 64'd1);
  endtask

  task automatic check_no_gap(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      chk(name, 64'(dec_valid), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (imem_req)
      chk("imem_addr_legal", 64'(imem_addr < 32'd16 && imem_addr[1:0] == 2'b00), 64'd1);
    if (dec_valid && dec_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h, expected no entry", dec_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", 64'(dec_pc), 64'(mon_e[31:0]));
        chk("pop_inst", 64'(dec_inst), 64'(mon_e[63:32]));
        chk("pop_fault", 64'(dec_fault), 64'(mon_e[64]));
        chk("pop_fetch_dec_reg", fetch_dec_reg, mon_e[63:0]);
      end
    end
  end

  initial begin
    int reqs;
    int pops_before;
    bit found;

    // Reset state
    dec_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc), 64'd0);
    chk("rst_dec_inst", 64'(dec_inst), 64'd0);
    chk("rst_dec_fault", 64'(dec_fault), 64'd0);
    chk("rst_fetch_dec_reg", fetch_dec_reg, 64'd0);

    // Streaming from RESET_PC with decode always ready; runs past the end of memory
    push_seq(32'h0, 40);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("c0_imem_req", 64'(imem_req), 64'd1);
    chk("c0_imem_addr", 64'(imem_addr), 64'd0);
    wait_valid("stream_first_valid", 4);
    check_no_gap("stream_no_gap", 8);

    // Asynchronous reset between edges with two entries queued
    @(posedge clk); #1 dec_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (occupancy == 3'd2) found = 1'b1;
    end
    chk("pre_reset_occupancy_2", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("async_rst_imem_req", 64'(imem_req), 64'd0);
    chk("async_rst_occupancy", 64'(occupancy), 64'd0);
    exp_q.delete();
    push_seq(32'h0, 40);

    // Decode stalled from reset: exactly DEPTH reads, then drain without a bubble
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) begin
        chk("stall_req_addr", 64'(imem_addr), 64'(4 * reqs));
        reqs++;
      end
    end
    chk("stall_req_count", 64'(reqs), 64'd4);
    chk("stall_occupancy_full", 64'(occupancy), 64'd4);
    chk("stall_req_idle", 64'(imem_req), 64'd0);
    @(posedge clk); #1 dec_ready = 1'b1;
    check_no_gap("drain_no_gap", 8);

    // Redirect with 3 entries queued and the PC 12 read in flight
    @(posedge clk); #1 rst = 1'b1; dec_ready = 1'b0; exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0043; dec_ready = 1'b1;
    push_seq(32'h0000_0040, 20);
    @(negedge clk);
    chk("redir_pre_occupancy", 64'(occupancy), 64'd3);
    chk("redir_cycle_dec_valid", 64'(dec_valid), 64'd0);
    chk("redir_cycle_imem_req", 64'(imem_req), 64'd0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("redir_imem_addr", 64'(imem_addr), 64'h40);
    chk("redir_occupancy", 64'(occupancy), 64'd0);
    chk("redir_out_of_range_req", 64'(imem_req), 64'd0);
    wait_valid("redir_valid", 4);
    repeat (4) @(negedge clk);

    // Redirect with a non-empty queue and ready high; PC adder wraps to 0
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    exp_q.delete();
    push_seq(32'hFFFF_FFFC, 20);
    @(negedge clk);
    chk("wrap_redir_pre_occupancy_nonzero", 64'(occupancy != 3'd0), 64'd1);
    chk("wrap_redir_dec_valid", 64'(dec_valid), 64'd0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("wrap_imem_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    chk("wrap_occupancy", 64'(occupancy), 64'd0);
    #1 pops_before = pops;
    wait_valid("wrap_valid", 4);
    check_no_gap("wrap_no_gap", 8);
    #1;
    chk("wrap_pop_count", 64'(pops - pops_before), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
